// File: rtl/i2s_loopback_receiver_pkg.sv
// Shared constants and helpers for the I2S loopback receiver.
//   WORD_BITS_DEF : default audio bits per L/R word
//   DUMMY_BITS    : leading BCK rises of each word that carry no sample data
//   FIFO_W        : width of one FIFO entry
//   SAMPLE_W/LSB  : sample field inside a FIFO entry
//   LANE_BIT      : lane tag position, RIGHT_BIT : channel tag position
package i2s_params;

  localparam int WORD_BITS_DEF = 24;
  localparam int DUMMY_BITS    = 1;
  localparam int FIFO_W        = 32;
  localparam int SAMPLE_W      = 24;
  localparam int SAMPLE_LSB    = 8;
  localparam int LANE_BIT      = 1;
  localparam int RIGHT_BIT     = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WR   = 1'b1
  } wr_state_t;

  // Packs one sample into the FIFO layout {sample, 6'b0, lane, right}.
  function automatic logic [FIFO_W-1:0] fifo_word(input logic [SAMPLE_W-1:0] sample,
                                                  input logic lane,
                                                  input logic right);
    logic [FIFO_W-1:0] w;
    w = '0;
    w[SAMPLE_LSB +: SAMPLE_W] = sample;
    w[LANE_BIT]  = lane;
    w[RIGHT_BIT] = right;
    return w;
  endfunction

endpackage

// File: rtl/i2s_loopback_receiver_if.sv
// FIFO write-side bus of the I2S loopback receiver.
//   rx_wren      : one-cycle write strobe
//   rx_fifo_data : entry to write, held while rx_wren is low
//   rx_full      : FIFO cannot accept a write this cycle
// master = receiver, slave = FIFO.
interface i2s_loopback_receiver_if;
  import i2s_params::*;

  logic              rx_wren;
  logic [FIFO_W-1:0] rx_fifo_data;
  logic              rx_full;

  modport master (output rx_wren, output rx_fifo_data, input rx_full);
  modport slave  (input rx_wren, input rx_fifo_data, output rx_full);

endinterface

// File: rtl/i2s_loopback_receiver_lane_deserializer.sv
// One serial lane: counts BCK rises since the last word boundary and shifts
// the sample bits in MSB first.
//   capture_clk, reset : clock and synchronous active-high reset
//   bck_rise           : registered BCK rising edge seen this cycle
//   boundary           : registered LRCK changed this cycle
//   data_bit           : registered serial bit of this lane
//   word               : bits shifted in so far for the current word
//   complete           : every sample bit of the current word has arrived
module i2s_lane_deserializer
  import i2s_params::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF
) (
  input  logic                 capture_clk,
  input  logic                 reset,
  input  logic                 bck_rise,
  input  logic                 boundary,
  input  logic                 data_bit,
  output logic [WORD_BITS-1:0] word,
  output logic                 complete
);

  localparam int FULL_CNT = WORD_BITS + DUMMY_BITS;
  localparam int CNT_W    = $clog2(FULL_CNT + 1);

  logic [CNT_W-1:0] cnt;

  // The counter saturates so padding rises after the last sample bit leave
  // both the count and the shifted word untouched.
  always_ff @(posedge capture_clk) begin
    if (reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (boundary) begin
      cnt <= '0;
    end else if (bck_rise) begin
      if (cnt != CNT_W'(FULL_CNT)) cnt <= cnt + 1'b1;
      if (cnt >= CNT_W'(DUMMY_BITS) && cnt < CNT_W'(FULL_CNT))
        word <= {word[WORD_BITS-2:0], data_bit};
    end
  end

  assign complete = (cnt == CNT_W'(FULL_CNT));

endmodule

// File: rtl/i2s_loopback_receiver.sv
// I2S receiver that captures the DAC-side serial stream back into a FIFO.
//   capture_clk, reset : only clock, synchronous active-high reset
//   i2s_bck/lrck/data  : bit clock, word select (0 = left), LANES data bits
//   fifo               : FIFO write bus (rx_wren, rx_fifo_data, rx_full)
//   rx_locked          : a left word start has been seen since reset
//   rx_overflow        : sticky, a word was dropped because the FIFO was full
//   rx_frame_err       : sticky, a word ended early or arrived while writing
module i2s_loopback_receiver
  import i2s_params::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int LANES     = 2
) (
  input  logic                   capture_clk,
  input  logic                   reset,
  input  logic                   i2s_bck,
  input  logic                   i2s_lrck,
  input  logic [LANES-1:0]       i2s_data,
  i2s_loopback_receiver_if.master fifo,
  output logic                   rx_locked,
  output logic                   rx_overflow,
  output logic                   rx_frame_err
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic             bck_p0, lrck_p0;
  logic [LANES-1:0] data_p0;
  logic             bck_p1, lrck_p1;

  // Stage p0: single input register (inputs share capture_clk's source).
  // Stage p1: previous registered value for edge detection.
  always_ff @(posedge capture_clk) begin
    if (reset) begin
      bck_p0  <= 1'b0;
      lrck_p0 <= 1'b0;
      data_p0 <= '0;
      bck_p1  <= 1'b0;
      lrck_p1 <= 1'b0;
    end else begin
      bck_p0  <= i2s_bck;
      lrck_p0 <= i2s_lrck;
      data_p0 <= i2s_data;
      bck_p1  <= bck_p0;
      lrck_p1 <= lrck_p0;
    end
  end

  logic bck_rise, boundary, lrck_fall;
  assign bck_rise  = bck_p0 & ~bck_p1;
  assign boundary  = lrck_p0 ^ lrck_p1;
  assign lrck_fall = lrck_p1 & ~lrck_p0;

  logic [WORD_BITS-1:0] words_w [LANES];
  logic [LANES-1:0]     complete_w;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    i2s_lane_deserializer #(.WORD_BITS(WORD_BITS)) u_lane (
      .capture_clk (capture_clk),
      .reset       (reset),
      .bck_rise    (bck_rise),
      .boundary    (boundary),
      .data_bit    (data_p0[g]),
      .word        (words_w[g]),
      .complete    (complete_w[g])
    );
  end

  wr_state_t            state, state_n;
  logic [LANE_W-1:0]    lane_q, lane_n;
  logic                 wren;
  logic                 start;
  logic [WORD_BITS-1:0] words_q [LANES];
  logic                 right_q;
  logic [FIFO_W-1:0]    last_q;
  logic [SAMPLE_W-1:0]  sample_w;
  logic [FIFO_W-1:0]    wdata;

  // A boundary while still writing the previous words is a framing fault.
  assign start = boundary & rx_locked & (&complete_w) & (state == ST_IDLE);

  // Stage p2: word latch, lock and sticky flags.
  always_ff @(posedge capture_clk) begin
    if (reset) begin
      rx_locked    <= 1'b0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
      right_q      <= 1'b0;
      last_q       <= '0;
      for (int i = 0; i < LANES; i++) words_q[i] <= '0;
    end else begin
      if (lrck_fall) rx_locked <= 1'b1;
      if (boundary && rx_locked && (!(&complete_w) || state != ST_IDLE))
        rx_frame_err <= 1'b1;
      if (start) begin
        words_q <= words_w;
        right_q <= lrck_p1;
      end
      if (state == ST_WR && fifo.rx_full) rx_overflow <= 1'b1;
      if (wren) last_q <= wdata;
    end
  end

  always_ff @(posedge capture_clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      lane_q <= '0;
    end else begin
      state  <= state_n;
      lane_q <= lane_n;
    end
  end

  // One cycle per lane; a full FIFO drops only that lane's word.
  always_comb begin
    state_n = state;
    lane_n  = lane_q;
    wren    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_WR;
          lane_n  = '0;
        end
      end
      ST_WR: begin
        wren = ~fifo.rx_full;
        if (lane_q == LANE_W'(LANES - 1)) state_n = ST_IDLE;
        else                              lane_n  = lane_q + 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Left-justify the word into the sample field for any WORD_BITS.
  always_comb begin
    sample_w = SAMPLE_W'({words_q[lane_q], {SAMPLE_W{1'b0}}} >> WORD_BITS);
    wdata    = fifo_word(sample_w, lane_q[0], right_q);
  end

  // Data shows the entry being written, otherwise the last written entry.
  assign fifo.rx_wren      = wren;
  assign fifo.rx_fifo_data = wren ? wdata : last_q;

endmodule

// File: tb/tb_i2s_loopback_receiver.sv
module tb_i2s_loopback_receiver;

  localparam int WB = 24;

  logic       capture_clk = 1'b0;
  logic       reset = 1'b1;
  logic       i2s_bck = 1'b0;
  logic       i2s_lrck = 1'b0;
  logic [1:0] i2s_data = 2'b00;
  logic       rx_locked, rx_overflow, rx_frame_err;

  i2s_loopback_receiver_if fifo_if ();

  i2s_loopback_receiver #(.WORD_BITS(WB), .LANES(2)) dut (
    .capture_clk  (capture_clk),
    .reset        (reset),
    .i2s_bck      (i2s_bck),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .fifo         (fifo_if),
    .rx_locked    (rx_locked),
    .rx_overflow  (rx_overflow),
    .rx_frame_err (rx_frame_err)
  );

  always #5 capture_clk = ~capture_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural model: expected FIFO entries and flag values.
  logic [31:0] exp_q[$];
  logic [31:0] seen[$];
  bit          m_locked = 0, m_ferr = 0, m_ovf = 0;
  bit          cur_lr = 0;
  int          cur_rises = 0;
  logic [23:0] cur_s0 = '0, cur_s1 = '0;
  bit          full_l1 = 0, rst_l1 = 0;

  function automatic logic [31:0] entry(input logic [23:0] s, input int lane, input bit right);
    return (32'(s) << 8) | (32'(lane) << 1) | 32'(right);
  endfunction

  task automatic model_boundary(input bit new_lr);
    if (m_locked) begin
      if (cur_rises >= WB + 1) begin
        exp_q.push_back(entry(cur_s0, 0, cur_lr));
        if (full_l1) m_ovf = 1;
        else if (!rst_l1) exp_q.push_back(entry(cur_s1, 1, cur_lr));
      end else begin
        m_ferr = 1;
      end
    end
    if (cur_lr && !new_lr) m_locked = 1;
  endtask

  task automatic check_flags();
    chk("locked", rx_locked, m_locked);
    chk("frame_err", rx_frame_err, m_ferr);
    chk("overflow", rx_overflow, m_ovf);
  endtask

  // mode: 0 plain, 1 check lock timing, 2 full during lane 1 slot, 3 reset in WR(0)
  task automatic send_word(input bit lr, input int rises, input int h,
                           input logic [23:0] s0, input logic [23:0] s1, input int mode);
    logic b0, b1;
    check_flags();
    full_l1 = (mode == 2);
    rst_l1  = (mode == 3);
    model_boundary(lr);
    full_l1 = 0;
    rst_l1  = 0;
    cur_lr = lr; cur_rises = rises; cur_s0 = s0; cur_s1 = s1;
    i2s_lrck = lr;
    i2s_bck  = 1'b0;
    if (mode == 1) begin
      fork
        begin
          @(negedge capture_clk); chk("lock_early", rx_locked, 1'b0);
          @(negedge capture_clk); chk("lock_rise", rx_locked, 1'b1);
        end
      join_none
    end else if (mode == 2) begin
      fork
        begin
          repeat (3) @(posedge capture_clk);
          #1 fifo_if.rx_full = 1'b1;
          @(posedge capture_clk);
          #1 fifo_if.rx_full = 1'b0;
        end
      join_none
    end else if (mode == 3) begin
      fork
        begin
          repeat (2) @(posedge capture_clk);
          #1 reset = 1'b1;
          m_locked = 0; m_ferr = 0; m_ovf = 0;
          @(posedge capture_clk);
          @(negedge capture_clk);
          chk("rst_wren", fifo_if.rx_wren, 1'b0);
          chk("rst_data", fifo_if.rx_fifo_data, 32'h0);
          chk("rst_locked", rx_locked, 1'b0);
          chk("rst_ovf", rx_overflow, 1'b0);
          chk("rst_ferr", rx_frame_err, 1'b0);
          @(posedge capture_clk);
          #1 reset = 1'b0;
        end
      join_none
    end
    for (int k = 1; k <= rises; k++) begin
      if (k >= 2 && k <= WB + 1) begin
        b0 = s0[WB + 1 - k];
        b1 = s1[WB + 1 - k];
      end else begin
        b0 = 1'($urandom);
        b1 = 1'($urandom);
      end
      i2s_data = {b1, b0};
      repeat (h) @(negedge capture_clk);
      i2s_bck = 1'b1;
      repeat (h) @(negedge capture_clk);
      i2s_bck = 1'b0;
    end
  endtask

  // Compare process: every write against the model, data held otherwise.
  initial begin
    logic [31:0] last;
    logic [31:0] e;
    bit rs;
    last = '0;
    forever begin
      @(posedge capture_clk);
      rs = reset;
      @(negedge capture_clk);
      if (rs) last = '0;
      if (fifo_if.rx_wren === 1'b1) begin
        seen.push_back(fifo_if.rx_fifo_data);
        chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write", fifo_if.rx_fifo_data, e);
          last = e;
        end
      end else begin
        chk("hold", fifo_if.rx_fifo_data, last);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] lits [4];
    int idx;
    lits[0] = 32'h12345600; lits[1] = 32'h80000002;
    lits[2] = 32'hABCDEF01; lits[3] = 32'h7FFFFF03;
    fifo_if.rx_full = 1'b0;
    repeat (3) @(negedge capture_clk);
    chk("reset_wren", fifo_if.rx_wren, 1'b0);
    chk("reset_data", fifo_if.rx_fifo_data, 32'h0);
    chk("reset_locked", rx_locked, 1'b0);
    chk("reset_ovf", rx_overflow, 1'b0);
    chk("reset_ferr", rx_frame_err, 1'b0);
    reset = 1'b0;

    // start mid-right-word, then DAC-style frames
    send_word(1, 10, 1, 24'($urandom), 24'($urandom), 0);
    chk("no_write_before_lock", seen.size(), 0);
    send_word(0, 128, 1, 24'h123456, 24'h800000, 1);
    send_word(1, 128, 1, 24'hABCDEF, 24'h7FFFFF, 0);
    send_word(0, 128, 1, 24'($urandom), 24'($urandom), 0);
    chk("lit_count", 32'(seen.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      chk("lit_word", (i < seen.size()) ? seen[i] : 32'h0, lits[i]);

    // short left word
    send_word(1, 128, 1, 24'($urandom), 24'($urandom), 0);
    send_word(0, 20, 1, 24'($urandom), 24'($urandom), 0);
    send_word(1, 128, 1, 24'($urandom), 24'($urandom), 0);
    send_word(0, 128, 1, 24'($urandom), 24'($urandom), 0);

    // FIFO full during lane 1 slot
    send_word(1, 128, 1, 24'($urandom), 24'($urandom), 2);
    send_word(0, 128, 1, 24'($urandom), 24'($urandom), 0);
    send_word(1, 128, 1, 24'($urandom), 24'($urandom), 0);

    // reset in WR(0), then relock on a fresh fall
    send_word(0, 64, 1, 24'($urandom), 24'($urandom), 3);
    send_word(1, 64, 1, 24'($urandom), 24'($urandom), 0);
    send_word(0, 128, 1, 24'($urandom), 24'($urandom), 1);
    send_word(1, 128, 1, 24'($urandom), 24'($urandom), 0);

    // slow BCK, all-ones left sample
    send_word(0, 32, 4, 24'hFFFFFF, 24'($urandom), 0);
    idx = seen.size();
    send_word(1, 32, 4, 24'($urandom), 24'($urandom), 0);
    chk("all_ones", (idx < seen.size()) ? seen[idx] : 32'h0, 32'hFFFFFF00);

    // random rates, lengths and samples
    for (int i = 0; i < 12; i++)
      send_word(~cur_lr, $urandom_range(25, 40), $urandom_range(1, 3),
                24'($urandom), 24'($urandom), 0);

    send_word(~cur_lr, 30, 1, 24'($urandom), 24'($urandom), 0);
    repeat (20) @(negedge capture_clk);
    check_flags();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
